// File: rtl/uart_image_loader_pkg.sv
// loader_pkg: constants and types shared by the UART image loader and the
// VGA display stage that reads the same frame buffer.
//   - FSM state enums for the loader and the byte receiver
//   - frame geometry (H_PIX, V_PIX, PIXELS, ADDR_W) and the frame header byte
//   - pixel field positions and a helper that assembles a pixel word
package loader_pkg;

    localparam int unsigned H_PIX  = 320;
    localparam int unsigned V_PIX  = 320;
    localparam int unsigned PIXELS = H_PIX * V_PIX;
    localparam int unsigned ADDR_W = 17;

    localparam logic [7:0] HEADER = 8'hA5;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned R_LSB = 0;
    localparam int unsigned R_MSB = 3;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned G_MSB = 7;
    localparam int unsigned B_LSB = 8;
    localparam int unsigned B_MSB = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // High byte carries blue in its low nibble; low byte carries green:red.
    function automatic logic [PIX_W-1:0] pack_pixel(input logic [3:0] hi_nib,
                                                    input logic [7:0] lo_byte);
        logic [PIX_W-1:0] p;
        p = '0;
        p[B_MSB:B_LSB] = hi_nib;
        p[G_MSB:G_LSB] = lo_byte[7:4];
        p[R_MSB:R_LSB] = lo_byte[3:0];
        return p;
    endfunction

endpackage

// File: rtl/uart_image_loader_uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with 2-FF input synchronizer,
// start-bit glitch rejection and stop-bit framing check.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   rx         in   serial input, idle high, asynchronous to clk
//   byte_valid out  one-cycle strobe, byte_data valid
//   byte_data  out  received byte (LSB received first)
//   frame_err  out  one-cycle strobe when the stop bit is sampled low
module uart_byte_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        r_state;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic             r_ferr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    // Edge-triggered so a line held low after a framing
                    // error does not immediately restart reception.
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_ferr;

endmodule

// File: rtl/uart_image_loader.sv
// uart_image_loader: receives a frame (header byte, then hi/lo byte per
// pixel in raster order) over UART and writes it into the frame-buffer
// BRAM write port.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset, aborts any frame
//   rx         in   UART serial input
//   bram_we    out  one-cycle write strobe per pixel
//   bram_addr  out  write address 0..PIXELS-1
//   bram_din   out  pixel {B[11:8], G[7:4], R[3:0]}
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse after the last pixel write
//   err        out  sticky error (timeout / framing), cleared by next header
module uart_image_loader #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD           = 115_200,
    parameter int unsigned PIXELS         = loader_pkg::PIXELS,
    parameter int unsigned ADDR_W         = loader_pkg::ADDR_W,
    parameter logic [7:0]  HEADER         = loader_pkg::HEADER,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [11:0]       bram_din,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);
    import loader_pkg::*;

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXELS - 1);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(w_byte_valid),
        .byte_data (w_byte_data),
        .frame_err (w_frame_err)
    );

    state_t            r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic [3:0]        r_hi;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [11:0]       r_din;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
            r_hi     <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            // Address advances in the cycle after the write strobe so the
            // strobe cycle presents the address actually written.
            if (r_we && (r_addr != ADDR_LAST)) begin
                r_addr <= r_addr + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_byte_valid && (w_byte_data == HEADER)) begin
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_state <= S_HI;
                    end
                end
                S_HI, S_LO: begin
                    // A byte arriving on the expiry cycle takes priority.
                    if (w_byte_valid) begin
                        r_to_cnt <= '0;
                        if (r_state == S_HI) begin
                            r_hi    <= w_byte_data[3:0];
                            r_state <= S_LO;
                        end else begin
                            r_we    <= 1'b1;
                            r_din   <= pack_pixel(r_hi, w_byte_data);
                            r_state <= (r_addr == ADDR_LAST) ? S_DONE : S_HI;
                        end
                    end else if (w_frame_err || (r_to_cnt == TO_LAST)) begin
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bram_we    = r_we;
    assign bram_addr  = r_addr;
    assign bram_din   = r_din;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_uart_image_loader.sv
module tb_uart_image_loader;

    localparam int unsigned CPB  = 16;
    localparam int unsigned NPIX = 4;
    localparam int unsigned TO   = 400;
    localparam int unsigned AW   = 17;

    logic          clk;
    logic          reset;
    logic          rx;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [11:0]   bram_din;
    logic          busy;
    logic          frame_done;
    logic          err;

    uart_image_loader #(
        .CLK_FREQ      (16),
        .BAUD          (1),
        .PIXELS        (NPIX),
        .ADDR_W        (AW),
        .HEADER        (8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed BRAM writes and frame_done pulses.
    int unsigned obs_addr[$];
    int unsigned obs_din[$];
    int unsigned obs_cyc[$];
    int unsigned done_cnt = 0;

    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            obs_addr.push_back(int'(bram_addr));
            obs_din.push_back(int'(bram_din));
            obs_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cnt = done_cnt + 1;
    end

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int unsigned stop_cyc;
    int unsigned exp_addr;

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        stop_cyc = cyc;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Reference model: pixel k of a frame goes to address k with value
    // (hi mod 16)*256 + lo; the write follows the stop-bit centre closely.
    task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input bit expect_wr);
        int unsigned n;
        int unsigned lat;
        n = obs_addr.size();
        send_byte(hi, 1'b1);
        send_byte(lo, 1'b1);
        if (expect_wr) begin
            check("wr_count", obs_addr.size(), n + 1);
            if (obs_addr.size() > n) begin
                check("wr_addr", obs_addr[n], exp_addr);
                check("wr_din", obs_din[n], (int'(hi) % 16) * 256 + int'(lo));
                lat = obs_cyc[n] - stop_cyc;
                check("wr_latency_ok", (lat >= 9 && lat <= 13) ? 1 : 0, 1);
            end
            exp_addr = exp_addr + 1;
        end else begin
            check("no_wr", obs_addr.size(), n);
        end
    endtask

    task automatic send_rand_frame(input string tag);
        int unsigned d0;
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        check({tag, "_busy_hdr"}, busy, 1);
        check({tag, "_err_hdr"}, err, 0);
        exp_addr = 0;
        for (int p = 0; p < NPIX; p++) begin
            if (p == 1) send_pixel(8'hA5, 8'hA5, 1'b1);
            else        send_pixel(8'($urandom), 8'($urandom), 1'b1);
        end
        repeat (4) @(negedge clk);
        check({tag, "_done"}, done_cnt, d0 + 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_addr_hold"}, bram_addr, NPIX - 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] fixed_px [8] = '{8'h0F, 8'h21, 8'h03, 8'h45, 8'h0A, 8'hBC, 8'h05, 8'h67};
    int unsigned d0;
    int unsigned n0;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_we", bram_we, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_din", bram_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Fixed frame.
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        check("t1_busy_hdr", busy, 1);
        exp_addr = 0;
        for (int p = 0; p < NPIX; p++) begin
            send_pixel(fixed_px[2*p], fixed_px[2*p+1], 1'b1);
            if (p == NPIX - 2) check("t1_no_early_done", done_cnt, d0);
        end
        repeat (4) @(negedge clk);
        check("t1_done_once", done_cnt, d0 + 1);
        check("t1_busy_end", busy, 0);
        check("t1_err", err, 0);
        check("t1_addr_hold", bram_addr, NPIX - 1);

        // Non-header bytes in IDLE are discarded.
        n0 = obs_addr.size();
        send_byte(8'h12, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("t2_no_wr", obs_addr.size(), n0);
        check("t2_busy", busy, 0);
        send_rand_frame("t2");

        // Inter-byte timeout.
        n0 = obs_addr.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (300) @(negedge clk);
        check("t3_busy_pre_to", busy, 1);
        check("t3_err_pre_to", err, 0);
        repeat (150) @(negedge clk);
        check("t3_err", err, 1);
        check("t3_busy", busy, 0);
        check("t3_no_wr", obs_addr.size(), n0);
        send_rand_frame("t3b");

        // Framing error inside a frame.
        n0 = obs_addr.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'($urandom), 1'b0);
        repeat (4) @(negedge clk);
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_no_wr", obs_addr.size(), n0);

        // Short low glitch in IDLE, then a header soon after.
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_err_sticky", err, 1);
        send_rand_frame("t5");

        // Reset mid-frame.
        send_byte(8'hA5, 1'b1);
        exp_addr = 0;
        send_pixel(8'($urandom), 8'($urandom), 1'b1);
        send_pixel(8'($urandom), 8'($urandom), 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_we", bram_we, 0);
        check("t6_addr", bram_addr, 0);
        check("t6_din", bram_din, 0);
        check("t6_busy", busy, 0);
        check("t6_done", frame_done, 0);
        check("t6_err", err, 0);
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        send_pixel(fixed_px[4], fixed_px[5], 1'b0);
        send_pixel(fixed_px[6], fixed_px[7], 1'b0);
        check("t6_busy_after", busy, 0);
        check("t6_no_done", done_cnt, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
